uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of uart_rx. Captures each byte when uart_rx raises flag, pulses uart_rx's clear input to re-arm it, and stores bytes in a circular FIFO. The host side pops bytes with a registered read port. Signals overflow when a byte arrives while the FIFO is full.

Parameters:
DEPTH, 8, number of byte entries; power of 2, minimum 2
WIDTH, 8, data width; must match uart_rx data
ACK_LEN, 2, cycles rx_clear is held high per acknowledge; minimum 1

Ports:
clk  input  1  system clock
clear  input  1  asynchronous, active-high reset for the whole block
rx_data  input  WIDTH  byte from uart_rx data
rx_flag  input  1  uart_rx byte-ready flag; level, held until uart_rx is cleared
rx_clear  output  1  drives uart_rx clear; acknowledge pulse
rd_en  input  1  pop request, sampled on the clk rising edge
rd_data  output  WIDTH  popped byte; registered
rd_valid  output  1  one-cycle strobe: rd_data holds a new byte
empty  output  1  count == 0
full  output  1  count == DEPTH
count  output  $clog2(DEPTH+1)  current occupancy
overflow  output  1  sticky: a byte was dropped
ovf_clr  input  1  synchronous clear of overflow

Behaviour:
- Reset (clear high, asynchronous): state IDLE; pointers 0; count 0; empty 1; full 0; rx_clear 0; rd_data 0; rd_valid 0; overflow 0.
- Capture FSM:
  - IDLE: when rx_flag = 1, go to CAPTURE.
  - CAPTURE, 1 cycle: if not full, write rx_data at wr_ptr and increment wr_ptr modulo DEPTH. If full, drop the byte and set overflow. Go to ACK.
  - ACK: rx_clear = 1 for ACK_LEN cycles, then go to WAIT_LOW.
  - WAIT_LOW: rx_clear = 0; when rx_flag = 0, go to IDLE. This guarantees one write per uart_rx byte, even if the flag stays high.
- rx_flag already high when reset deasserts: that byte is captured normally.
- Write latency: rx_flag rises at edge N; the byte is stored and count is updated at edge N+2; rx_clear is high during cycles N+2 through N+1+ACK_LEN.
- Read: rd_en = 1 and not empty at an edge loads rd_data from rd_ptr, increments rd_ptr modulo DEPTH, and drives rd_valid = 1 for the following cycle.
  - rd_en while empty is ignored: rd_data holds, rd_valid = 0, no error.
  - rd_valid is 0 in any cycle without an accepted pop.
- Simultaneous write (CAPTURE) and accepted read in the same cycle: count unchanged, and both pointers advance.
  - If full in the same cycle, the write is still dropped, because full is evaluated before the read.
  - If empty, only the write happens, because the read is rejected. There is no read-through bypass.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count is a separate up/down counter; full and empty are derived from count.
- overflow: set on a dropped write; cleared by ovf_clr. If both happen in the same cycle, set wins.
- Reset mid-byte (clear during ACK): rx_clear drops immediately; FIFO contents are lost.
- No combinational path from rd_en to any output, or from rx_flag to rx_clear.

Decomposition:
- Shared package/include holds: FSM state encodings (IDLE, CAPTURE, ACK, WAIT_LOW, 2-bit), UART_WIDTH = 8, default FIFO depth.
- One sub-module is natural: sync_fifo (storage, pointers, count, full/empty, registered read).
- uart_rx_fifo holds the capture FSM, the rx_clear generator and the overflow flag.

Test Plan:
- Reset, then rx_data = 0x55 with rx_flag held high until rx_clear is seen -> count goes 0→1 two edges after flag rise; rx_clear high for exactly 2 cycles; empty = 0; rd_en pulse -> next cycle rd_valid = 1, rd_data = 0x55, empty = 1.
- Write 8 bytes 0x01..0x08 (DEPTH = 8) -> full = 1, count = 8. A ninth byte 0xAA -> still acknowledged, overflow = 1, count = 8. Pop all -> 0x01..0x08 in order; 0xAA never appears.
- Pointer wrap: write 6, read 6, write 5, read 5 using bytes 0x10..0x1A -> output order preserved across the wrap, and count returns to 0.
- Simultaneous write and pop with count = 3 -> count stays 3 and the popped byte is the oldest. Same test at count = 8 -> write dropped, overflow set, count = 7 after the edge.
- rx_flag held high for 50 cycles after the ack -> exactly one write. A second flag edge after a low period -> a second write. ovf_clr and overflow set in the same cycle -> overflow stays 1.
- Assert clear during ACK with count = 4 -> rx_clear = 0, count = 0, empty = 1, rd_valid = 0, all asynchronously before the next clk edge.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the uart_rx receive buffer: capture FSM encoding and
// default widths/depths.
package uart_rx_fifo_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CAPTURE  = 2'd1,
      ACK      = 2'd2,
      WAIT_LOW = 2'd3
   } cap_state_t;

   localparam int UART_WIDTH         = 8;
   localparam int FIFO_DEPTH_DEFAULT = 8;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Circular byte FIFO with occupancy counter and a registered, strobed read port.
// Writes while full and reads while empty are ignored.
module uart_rx_fifo_sync_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int  DEPTH = FIFO_DEPTH_DEFAULT,
   parameter int  WIDTH = UART_WIDTH,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             empty,
   output logic             full,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic [WIDTH-1:0] rd_data_reg;
   logic             rd_valid_reg;
   logic             do_wr;
   logic             do_rd;

   // full/empty come from the current count, so a write in the same cycle as a
   // pop is still refused when full and a pop is refused when empty.
   assign empty = (count_reg == '0);
   assign full  = (count_reg == CW'(DEPTH));
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   // Storage has no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         rd_data_reg  <= '0;
         rd_valid_reg <= 1'b0;
      end else begin
         rd_valid_reg <= do_rd;
         if (do_wr) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         end
         if (do_rd) begin
            rd_ptr_reg  <= rd_ptr_reg + PW'(1);
            rd_data_reg <= mem[rd_ptr_reg];
         end
         if (do_wr && !do_rd) begin
            count_reg <= count_reg + CW'(1);
         end else if (do_rd && !do_wr) begin
            count_reg <= count_reg - CW'(1);
         end
      end
   end

   assign rd_data  = rd_data_reg;
   assign rd_valid = rd_valid_reg;
   assign count    = count_reg;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind uart_rx: captures each flagged byte once, acknowledges
// it with an rx_clear pulse, and queues it for the host. Sticky overflow on drop.
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int  DEPTH   = FIFO_DEPTH_DEFAULT,
   parameter int  WIDTH   = UART_WIDTH,
   parameter int  ACK_LEN = 2,
   localparam int CW      = $clog2(DEPTH + 1),
   localparam int AW      = (ACK_LEN > 1) ? $clog2(ACK_LEN) : 1
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [WIDTH-1:0] rx_data,
   input  logic             rx_flag,
   output logic             rx_clear,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             empty,
   output logic             full,
   output logic [CW-1:0]    count,
   output logic             overflow,
   input  logic             ovf_clr
);

   cap_state_t    state_reg;
   cap_state_t    state_next;
   logic [AW-1:0] ack_cnt_reg;
   logic [AW-1:0] ack_cnt_next;
   logic          capture;
   logic          drop;
   logic          overflow_reg;

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_reg   <= IDLE;
         ack_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         ack_cnt_reg <= ack_cnt_next;
      end
   end

   // rx_clear is decoded from state only, so rx_flag never reaches it combinationally.
   always_comb begin
      state_next   = state_reg;
      ack_cnt_next = ack_cnt_reg;
      rx_clear     = 1'b0;
      capture      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (rx_flag) begin
               state_next = CAPTURE;
            end
         end
         CAPTURE: begin
            capture      = 1'b1;
            ack_cnt_next = '0;
            state_next   = ACK;
         end
         ACK: begin
            rx_clear = 1'b1;
            if (ack_cnt_reg == AW'(ACK_LEN - 1)) begin
               state_next = WAIT_LOW;
            end else begin
               ack_cnt_next = ack_cnt_reg + AW'(1);
            end
         end
         WAIT_LOW: begin
            // A flag still high here is the byte already taken, not a new one.
            if (!rx_flag) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign drop = capture && full;

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         overflow_reg <= 1'b0;
      end else if (drop) begin
         overflow_reg <= 1'b1;
      end else if (ovf_clr) begin
         overflow_reg <= 1'b0;
      end
   end

   assign overflow = overflow_reg;

   uart_rx_fifo_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_fifo (
      .clk      (clk),
      .clear    (clear),
      .wr_en    (capture),
      .wr_data  (rx_data),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .empty    (empty),
      .full     (full),
      .count    (count)
   );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: table-driven fill/pop plus hand-written
// sequences for latency, wrap, simultaneous access, held flag and async reset.
module tb_uart_rx_fifo;

   localparam int DEPTH   = 8;
   localparam int WIDTH   = 8;
   localparam int ACK_LEN = 2;

   logic       clk = 1'b0;
   logic       clear;
   logic [7:0] rx_data;
   logic       rx_flag;
   logic       rx_clear;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       empty;
   logic       full;
   logic [3:0] count;
   logic       overflow;
   logic       ovf_clr;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] data;
      logic [3:0] exp_count;
      logic       exp_full;
      logic       exp_ovf;
   } wr_vec_t;

   wr_vec_t fill_tab [9];

   uart_rx_fifo #(
      .DEPTH   (DEPTH),
      .WIDTH   (WIDTH),
      .ACK_LEN (ACK_LEN)
   ) dut (
      .clk      (clk),
      .clear    (clear),
      .rx_data  (rx_data),
      .rx_flag  (rx_flag),
      .rx_clear (rx_clear),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .empty    (empty),
      .full     (full),
      .count    (count),
      .overflow (overflow),
      .ovf_clr  (ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance until rx_clear is seen; a missing acknowledge counts as a failure.
   task automatic wait_ack(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (rx_clear) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s: got no rx_clear expected rx_clear within 20 cycles", name);
      end
   endtask

   // uart_rx model: flag held until acknowledged, then dropped.
   task automatic send_byte(input logic [7:0] d);
      rx_data = d;
      rx_flag = 1'b1;
      wait_ack($sformatf("ack %02h", d));
      rx_flag = 1'b0;
      repeat (ACK_LEN + 2) step();
   endtask

   task automatic pop(input logic [7:0] exp);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check($sformatf("pop valid %02h", exp), 32'(rd_valid), 32'd1);
      check($sformatf("pop data %02h", exp), 32'(rd_data), 32'(exp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      fill_tab[0] = '{8'h01, 4'd1, 1'b0, 1'b0};
      fill_tab[1] = '{8'h02, 4'd2, 1'b0, 1'b0};
      fill_tab[2] = '{8'h03, 4'd3, 1'b0, 1'b0};
      fill_tab[3] = '{8'h04, 4'd4, 1'b0, 1'b0};
      fill_tab[4] = '{8'h05, 4'd5, 1'b0, 1'b0};
      fill_tab[5] = '{8'h06, 4'd6, 1'b0, 1'b0};
      fill_tab[6] = '{8'h07, 4'd7, 1'b0, 1'b0};
      fill_tab[7] = '{8'h08, 4'd8, 1'b1, 1'b0};
      fill_tab[8] = '{8'hAA, 4'd8, 1'b1, 1'b1};

      clear   = 1'b1;
      rx_data = 8'h00;
      rx_flag = 1'b0;
      rd_en   = 1'b0;
      ovf_clr = 1'b0;
      #1;
      check("reset empty", 32'(empty), 32'd1);
      check("reset full", 32'(full), 32'd0);
      check("reset count", 32'(count), 32'd0);
      check("reset rx_clear", 32'(rx_clear), 32'd0);
      check("reset rd_data", 32'(rd_data), 32'd0);
      check("reset rd_valid", 32'(rd_valid), 32'd0);
      check("reset overflow", 32'(overflow), 32'd0);
      repeat (2) @(posedge clk);
      #1 clear = 1'b0;
      step();

      // Latency: flag driven after edge N, stored at N+2, rx_clear for ACK_LEN cycles.
      rx_data = 8'h55;
      rx_flag = 1'b1;
      step();
      check("lat count N+1", 32'(count), 32'd0);
      check("lat rx_clear N+1", 32'(rx_clear), 32'd0);
      step();
      check("lat count N+2", 32'(count), 32'd1);
      check("lat rx_clear N+2", 32'(rx_clear), 32'd1);
      check("lat empty N+2", 32'(empty), 32'd0);
      rx_flag = 1'b0;
      step();
      check("lat rx_clear N+3", 32'(rx_clear), 32'd1);
      step();
      check("lat rx_clear N+4", 32'(rx_clear), 32'd0);
      repeat (2) step();
      pop(8'h55);
      check("lat empty after pop", 32'(empty), 32'd1);
      step();
      check("rd_valid one cycle", 32'(rd_valid), 32'd0);

      // Fill to full, then one more byte that is acknowledged but dropped.
      for (int i = 0; i < 9; i++) begin
         send_byte(fill_tab[i].data);
         check($sformatf("fill count %02h", fill_tab[i].data), 32'(count), 32'(fill_tab[i].exp_count));
         check($sformatf("fill full %02h", fill_tab[i].data), 32'(full), 32'(fill_tab[i].exp_full));
         check($sformatf("fill ovf %02h", fill_tab[i].data), 32'(overflow), 32'(fill_tab[i].exp_ovf));
      end
      for (int i = 0; i < 8; i++) begin
         pop(fill_tab[i].data);
      end
      check("drain empty", 32'(empty), 32'd1);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("pop empty rd_valid", 32'(rd_valid), 32'd0);
      check("pop empty rd_data holds", 32'(rd_data), 32'h08);
      check("pop empty count", 32'(count), 32'd0);

      // Pointer wrap.
      for (int i = 0; i < 6; i++) send_byte(8'(8'h10 + i));
      check("wrap count 6", 32'(count), 32'd6);
      for (int i = 0; i < 6; i++) pop(8'(8'h10 + i));
      for (int i = 0; i < 5; i++) send_byte(8'(8'h16 + i));
      check("wrap count 5", 32'(count), 32'd5);
      for (int i = 0; i < 5; i++) pop(8'(8'h16 + i));
      check("wrap count 0", 32'(count), 32'd0);

      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      check("ovf_clr clears", 32'(overflow), 32'd0);

      // Simultaneous capture and pop at count 3.
      send_byte(8'h20);
      send_byte(8'h21);
      send_byte(8'h22);
      rx_data = 8'h23;
      rx_flag = 1'b1;
      step();
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("simul3 count", 32'(count), 32'd3);
      check("simul3 rd_valid", 32'(rd_valid), 32'd1);
      check("simul3 rd_data", 32'(rd_data), 32'h20);
      check("simul3 rx_clear", 32'(rx_clear), 32'd1);
      rx_flag = 1'b0;
      repeat (4) step();

      // Simultaneous capture and pop while full: write dropped.
      for (int i = 0; i < 5; i++) send_byte(8'(8'h24 + i));
      check("simul8 pre full", 32'(full), 32'd1);
      rx_data = 8'h99;
      rx_flag = 1'b1;
      step();
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("simul8 count", 32'(count), 32'd7);
      check("simul8 overflow", 32'(overflow), 32'd1);
      check("simul8 rd_data", 32'(rd_data), 32'h21);
      check("simul8 rx_clear", 32'(rx_clear), 32'd1);
      rx_flag = 1'b0;
      repeat (4) step();
      for (int i = 0; i < 7; i++) pop(8'(8'h22 + i));
      check("simul8 drained", 32'(empty), 32'd1);

      // Flag held high long after the acknowledge: one write only.
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      rx_data = 8'h31;
      rx_flag = 1'b1;
      wait_ack("ack held 31");
      repeat (50) step();
      check("held flag one write", 32'(count), 32'd1);
      rx_flag = 1'b0;
      repeat (3) step();
      send_byte(8'h32);
      check("second edge write", 32'(count), 32'd2);
      pop(8'h31);
      pop(8'h32);

      // ovf_clr in the same cycle as a drop: set wins.
      for (int i = 0; i < 8; i++) send_byte(8'(8'h40 + i));
      check("collide pre ovf", 32'(overflow), 32'd0);
      rx_data = 8'hEE;
      rx_flag = 1'b1;
      step();
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      check("collide overflow", 32'(overflow), 32'd1);
      check("collide count", 32'(count), 32'd8);
      rx_flag = 1'b0;
      repeat (4) step();
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      check("ovf_clr alone", 32'(overflow), 32'd0);

      // Async clear during ACK with count 4 and a pop strobe in flight.
      for (int i = 0; i < 4; i++) pop(8'(8'h40 + i));
      rx_data = 8'h50;
      rx_flag = 1'b1;
      step();
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("midack rx_clear", 32'(rx_clear), 32'd1);
      check("midack count", 32'(count), 32'd4);
      check("midack rd_valid", 32'(rd_valid), 32'd1);
      check("midack rd_data", 32'(rd_data), 32'h44);
      #2 clear = 1'b1;
      rx_data = 8'h77;
      #1;
      check("async rx_clear", 32'(rx_clear), 32'd0);
      check("async count", 32'(count), 32'd0);
      check("async empty", 32'(empty), 32'd1);
      check("async rd_valid", 32'(rd_valid), 32'd0);
      check("async rd_data", 32'(rd_data), 32'd0);

      // Flag already high when reset releases: captured normally.
      @(posedge clk);
      #1 clear = 1'b0;
      wait_ack("ack flag at reset");
      rx_flag = 1'b0;
      repeat (4) step();
      check("flag at reset count", 32'(count), 32'd1);
      pop(8'h77);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
